// File: rtl/csa_accumulator.sv
// Carry-save group accumulator: 4:2-compresses redundant (sum, carry) beats, resolves once per group.
// Optional CSA_ACC_SAT_EN: saturate out_data on overflow instead of two's-complement wrap.
module csa_accumulator #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned COUNT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic [WIDTH-1:0]     in_carry,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_overflow,
  output logic                 busy
);

  localparam int unsigned IW = WIDTH + COUNT_BITS + 1;
  localparam int unsigned CW = COUNT_BITS + 1;
  localparam logic [CW-1:0] CNT_MAX = {1'b1, {COUNT_BITS{1'b0}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, HOLD} state_t;

  state_t          state;
  logic [IW-1:0]   acc_s, acc_c;
  logic [CW-1:0]   cnt;

  logic [IW-1:0]   op_a, op_b, s1, c1, s2, c2, total;
  logic [CW-1:0]   cnt_nxt;
  logic            beat_acc, group_end, ovf_c;
  logic [ACC_WIDTH-1:0] res_c;

  // 4:2 compressor built from two stacked 3:2 stages; carries shift left, MSB drops.
  always_comb begin
    op_a = {{(IW-WIDTH){in_sum[WIDTH-1]}}, in_sum};
    op_b = {{(IW-WIDTH){in_carry[WIDTH-1]}}, in_carry};
    s1   = acc_s ^ acc_c ^ op_a;
    c1   = ((acc_s & acc_c) | (acc_s & op_a) | (acc_c & op_a)) << 1;
    s2   = s1 ^ c1 ^ op_b;
    c2   = ((s1 & c1) | (s1 & op_b) | (c1 & op_b)) << 1;
  end

  // Group control terms and the single carry-propagate resolve.
  always_comb begin
    beat_acc  = in_valid && in_ready;
    cnt_nxt   = cnt + CW'(1);
    group_end = in_last || (cnt_nxt == CNT_MAX);
    total     = acc_s + acc_c;
    ovf_c     = !((&total[IW-1:ACC_WIDTH-1]) || !(|total[IW-1:ACC_WIDTH-1]));
`ifdef CSA_ACC_SAT_EN
    if (ovf_c) res_c = total[IW-1] ? SAT_MIN : SAT_MAX;
    else       res_c = total[ACC_WIDTH-1:0];
`else
    res_c = total[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc_s        <= '0;
      acc_c        <= '0;
      cnt          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (beat_acc) begin
            acc_s <= s2;
            acc_c <= c2;
            cnt   <= cnt_nxt;
            busy  <= 1'b1;
            if (group_end) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          out_data     <= res_c;
          out_overflow <= ovf_c;
          out_valid    <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            acc_s     <= '0;
            acc_c     <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed, table-driven bench for csa_accumulator plus hand-written backpressure/reset sequences.
module tb_csa_accumulator;

  localparam int W  = 16;
  localparam int AW = 20;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_overflow, busy;
  logic [W-1:0]  in_sum, in_carry;
  logic [AW-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  csa_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    int            rep;
    bit            last;
    bit            do_chk;
    logic [AW-1:0] exp_wrap;
    logic [AW-1:0] exp_sat;
    bit            exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Presents one beat from a negedge and returns at the negedge after it was taken.
  task automatic send_beat(input logic [W-1:0] s, input logic [W-1:0] c, input logic last);
    int k;
    in_sum = s; in_carry = c; in_last = last; in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the negedge after the last beat edge: checks 2-cycle latency, result, handshake.
  task automatic get_result(input string name, input logic [AW-1:0] ed, input logic eo);
    chk({name, "_lat_valid_lo"}, 32'(out_valid), 32'd0);
    chk({name, "_lat_ready_lo"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_ready_lo"}, 32'(in_ready), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(ed));
    chk({name, "_ovf"}, 32'(out_overflow), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_post_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t tbl[12];
    logic [AW-1:0] ed;

    tbl[0]  = '{16'd5,    16'd3,    1,  1'b1, 1'b1, 20'd8,      20'd8,      1'b0};
    tbl[1]  = '{16'hFF9C, 16'd40,   1,  1'b0, 1'b0, 20'd0,      20'd0,      1'b0};
    tbl[2]  = '{16'd7,    16'hFFF9, 1,  1'b0, 1'b0, 20'd0,      20'd0,      1'b0};
    tbl[3]  = '{16'd1000, 16'd24,   1,  1'b1, 1'b1, 20'd964,    20'd964,    1'b0};
    tbl[4]  = '{16'h7FFF, 16'h7FFF, 16, 1'b0, 1'b1, 20'hFFFE0,  20'h7FFFF,  1'b1};
    tbl[5]  = '{16'h8000, 16'h8000, 16, 1'b0, 1'b1, 20'h00000,  20'h80000,  1'b1};
    tbl[6]  = '{16'h7FFF, 16'h7FFF, 8,  1'b0, 1'b0, 20'd0,      20'd0,      1'b0};
    tbl[7]  = '{16'd15,   16'd0,    1,  1'b1, 1'b1, 20'h7FFFF,  20'h7FFFF,  1'b0};
    tbl[8]  = '{16'h7FFF, 16'h7FFF, 8,  1'b0, 1'b0, 20'd0,      20'd0,      1'b0};
    tbl[9]  = '{16'd16,   16'd0,    1,  1'b1, 1'b1, 20'h80000,  20'h7FFFF,  1'b1};
    tbl[10] = '{16'h8000, 16'h8000, 8,  1'b1, 1'b1, 20'h80000,  20'h80000,  1'b0};
    tbl[11] = '{16'hFFFB, 16'hFFFD, 1,  1'b1, 1'b1, 20'hFFFF8,  20'hFFFF8,  1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_sum = '0; in_carry = '0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_after_edge", 32'(in_ready), 32'd1);

    // Table-driven groups
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < tbl[i].rep; r++)
        send_beat(tbl[i].s, tbl[i].c, (r == tbl[i].rep - 1) ? tbl[i].last : 1'b0);
      if (tbl[i].do_chk) begin
`ifdef CSA_ACC_SAT_EN
        ed = tbl[i].exp_sat;
`else
        ed = tbl[i].exp_wrap;
`endif
        get_result($sformatf("vec%0d", i), ed, tbl[i].exp_ovf);
      end
    end

    // Backpressure in HOLD with a pending beat upstream
    send_beat(16'd9, 16'd1, 1'b1);
    @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_sum = 16'd111; in_carry = 16'd0; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", k), 32'(out_data), 32'd10);
      chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    get_result("bp_next", 20'd111, 1'b0);

    // Reset in the middle of an open group
    for (int k = 0; k < 3; k++) send_beat(16'd100, 16'd0, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ovf", 32'(out_overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    send_beat(16'd2, 16'd2, 1'b1);
    get_result("after_rst", 20'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
